// File: rtl/alu_uart_sequencer.sv
// Byte-stream sequencer for the shared ALU: collects A, B and opcode bytes, then returns the result over valid/ready.
// Optional inter-byte timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer #(
   parameter int unsigned NB_DATA = 8,
   parameter int unsigned NB_OP   = 6,
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_valid,
   output logic [NB_DATA-1:0] o_alu_data_A,
   output logic [NB_DATA-1:0] o_alu_data_B,
   output logic [NB_OP-1:0]   o_alu_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_timeout
);

   typedef enum logic [2:0] {
      S_WAIT_A,
      S_WAIT_B,
      S_WAIT_OP,
      S_EXEC,
      S_SEND
   } state_e;

   state_e             state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d;
   logic [NB_DATA-1:0] b_q, b_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic [NB_DATA-1:0] tx_q, tx_d;
   logic               txv_q, txv_d;
   logic               expire_c;

   if (TIMEOUT < 2) begin : g_timeout_chk
      $error("TIMEOUT must be >= 2");
   end

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q;
   logic             counting_c;

   // Counter idles at zero outside the operand/opcode waits and restarts on every accepted byte.
   always_comb begin
      cnt_d      = '0;
      expire_c   = 1'b0;
      counting_c = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
      if (counting_c && !i_rx_valid) begin
         if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            expire_c = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= expire_c;
      end
   end

   assign o_timeout = tmo_q;
`else
   assign expire_c  = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // Next-state and register updates; a byte arriving in the expiry cycle takes priority.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      tx_d    = tx_q;
      txv_d   = txv_q;
      case (state_q)
         S_WAIT_A: begin
            if (i_rx_valid) begin
               a_d     = i_rx_data;
               state_d = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (i_rx_valid) begin
               b_d     = i_rx_data;
               state_d = S_WAIT_OP;
            end else if (expire_c) begin
               state_d = S_WAIT_A;
            end
         end
         S_WAIT_OP: begin
            if (i_rx_valid) begin
               op_d    = i_rx_data[NB_OP-1:0];
               state_d = S_EXEC;
            end else if (expire_c) begin
               state_d = S_WAIT_A;
            end
         end
         S_EXEC: begin
            tx_d    = i_alu_result;
            txv_d   = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (txv_q && i_tx_ready) begin
               txv_d   = 1'b0;
               state_d = S_WAIT_A;
            end
         end
         default: begin
            state_d = S_WAIT_A;
            txv_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_WAIT_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         tx_q    <= '0;
         txv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         tx_q    <= tx_d;
         txv_q   <= txv_d;
      end
   end

   assign o_alu_data_A = a_q;
   assign o_alu_data_B = b_q;
   assign o_alu_op     = op_q;
   assign o_tx_data    = tx_q;
   assign o_tx_valid   = txv_q;
   assign o_busy       = (state_q != S_WAIT_A);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench for alu_uart_sequencer: vector table of full transactions plus
// hand-written backpressure, ignored-RX, async-reset and timeout sequences.
module tb_alu_uart_sequencer;

   localparam int unsigned NB_DATA = 8;
   localparam int unsigned NB_OP   = 6;
   localparam int unsigned TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NB_DATA-1:0] rx_data;
   logic               rx_valid;
   logic [NB_DATA-1:0] alu_a, alu_b, alu_res, tx_data;
   logic [NB_OP-1:0]   alu_op;
   logic               tx_valid, tx_ready, busy, timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_uart_sequencer #(
      .NB_DATA(NB_DATA),
      .NB_OP  (NB_OP),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .o_alu_data_A(alu_a),
      .o_alu_data_B(alu_b),
      .o_alu_op    (alu_op),
      .i_alu_result(alu_res),
      .o_tx_data   (tx_data),
      .o_tx_valid  (tx_valid),
      .i_tx_ready  (tx_ready),
      .o_busy      (busy),
      .o_timeout   (timeout)
   );

   // Stand-in ALU driven by the sequencer outputs
   always_comb begin
      case (alu_op)
         6'h20:   alu_res = alu_a + alu_b;
         6'h22:   alu_res = alu_a - alu_b;
         6'h24:   alu_res = alu_a & alu_b;
         6'h25:   alu_res = alu_a | alu_b;
         6'h26:   alu_res = alu_a ^ alu_b;
         6'h27:   alu_res = ~(alu_a | alu_b);
         6'h03:   alu_res = NB_DATA'($signed(alu_a) >>> alu_b);
         6'h02:   alu_res = alu_a >> alu_b;
         default: alu_res = '0;
      endcase
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] opb;
      logic [5:0] exp_op;
      logic [7:0] exp_res;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Full transaction with the transmitter ready; checks EXEC cycle, one-cycle valid, return to idle.
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input logic [5:0] exp_op, input logic [7:0] exp_res, input string tag);
      tx_ready = 1'b1;
      send_byte(a);
      send_byte(b);
      send_byte(opb);
      chk({tag, " exec_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, " exec_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, " valid"}, 32'(tx_valid), 32'd1);
      chk({tag, " tx_data"}, 32'(tx_data), 32'(exp_res));
      chk({tag, " op"}, 32'(alu_op), 32'(exp_op));
      chk({tag, " A"}, 32'(alu_a), 32'(a));
      chk({tag, " B"}, 32'(alu_b), 32'(b));
      @(negedge clk);
      chk({tag, " valid_clr"}, 32'(tx_valid), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
      vecs[1]  = '{8'h05, 8'h03, 8'h22, 6'h22, 8'h02};
      vecs[2]  = '{8'h3C, 8'h0F, 8'h24, 6'h24, 8'h0C};
      vecs[3]  = '{8'h3C, 8'h0F, 8'h25, 6'h25, 8'h3F};
      vecs[4]  = '{8'hFF, 8'h0F, 8'h26, 6'h26, 8'hF0};
      vecs[5]  = '{8'h01, 8'h01, 8'hE0, 6'h20, 8'h02};
      vecs[6]  = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
      vecs[7]  = '{8'h10, 8'h20, 8'h22, 6'h22, 8'hF0};
      vecs[8]  = '{8'h81, 8'h02, 8'h03, 6'h03, 8'hE0};
      vecs[9]  = '{8'h81, 8'h02, 8'h02, 6'h02, 8'h20};
      vecs[10] = '{8'h0C, 8'h03, 8'h27, 6'h27, 8'hF0};
      vecs[11] = '{8'h55, 8'h0F, 8'h66, 6'h26, 8'h5A};

      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      #12;
      chk("rst A", 32'(alu_a), 32'd0);
      chk("rst B", 32'(alu_b), 32'd0);
      chk("rst op", 32'(alu_op), 32'd0);
      chk("rst tx_data", 32'(tx_data), 32'd0);
      chk("rst valid", 32'(tx_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst timeout", 32'(timeout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].exp_op, vecs[i].exp_res,
                 $sformatf("vec%0d", i));
      end

      // Backpressure with a stray RX byte during SEND
      tx_ready = 1'b0;
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'h22);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("bp valid c%0d", k), 32'(tx_valid), 32'd1);
         chk($sformatf("bp data c%0d", k), 32'(tx_data), 32'h02);
         if (k == 2) begin
            rx_data  = 8'hAA;
            rx_valid = 1'b1;
         end else begin
            rx_valid = 1'b0;
            rx_data  = 8'h00;
         end
      end
      chk("ign A", 32'(alu_a), 32'h05);
      chk("ign B", 32'(alu_b), 32'h03);
      chk("ign op", 32'(alu_op), 32'h22);
      chk("bp busy", 32'(busy), 32'd1);
      tx_ready = 1'b1;
      @(negedge clk);
      chk("bp valid_clr", 32'(tx_valid), 32'd0);
      chk("bp idle", 32'(busy), 32'd0);
      run_txn(8'h01, 8'h01, 8'h20, 6'h20, 8'h02, "after_ign");

      // Async reset mid-transaction, no clock edge needed
      send_byte(8'h05);
      send_byte(8'h03);
      chk("pre_rst busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst A", 32'(alu_a), 32'd0);
      chk("arst B", 32'(alu_b), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      #1 rst_n = 1'b1;
      run_txn(8'h02, 8'h03, 8'h20, 6'h20, 8'h05, "post_arst");

      // Reset discards a pending TX byte
      tx_ready = 1'b0;
      send_byte(8'h07);
      send_byte(8'h01);
      send_byte(8'h20);
      @(negedge clk);
      chk("pend valid", 32'(tx_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("pend discard", 32'(tx_valid), 32'd0);
      chk("pend tx_data", 32'(tx_data), 32'd0);
      #1 rst_n = 1'b1;
      tx_ready = 1'b1;

`ifdef ALU_SEQ_TIMEOUT_EN
      send_byte(8'h05);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("tmo quiet c%0d", k), 32'(timeout), 32'd0);
         @(negedge clk);
      end
      chk("tmo pulse", 32'(timeout), 32'd1);
      chk("tmo idle", 32'(busy), 32'd0);
      chk("tmo keep A", 32'(alu_a), 32'h05);
      @(negedge clk);
      chk("tmo one_cycle", 32'(timeout), 32'd0);

      send_byte(8'h05);
      for (int k = 1; k < 16; k++) @(negedge clk);
      rx_data  = 8'h07;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      chk("edge no_tmo", 32'(timeout), 32'd0);
      chk("edge busy", 32'(busy), 32'd1);
      chk("edge B", 32'(alu_b), 32'h07);
      @(negedge clk);
      chk("edge no_tmo2", 32'(timeout), 32'd0);
      send_byte(8'h20);
      @(negedge clk);
      chk("edge result", 32'(tx_data), 32'h0C);
      chk("edge valid", 32'(tx_valid), 32'd1);
      @(negedge clk);
      chk("edge done", 32'(busy), 32'd0);
`else
      send_byte(8'h05);
      for (int k = 0; k < 40; k++) @(negedge clk);
      chk("nomacro timeout", 32'(timeout), 32'd0);
      chk("nomacro wait", 32'(busy), 32'd1);
      send_byte(8'h03);
      send_byte(8'h20);
      @(negedge clk);
      chk("nomacro result", 32'(tx_data), 32'h08);
      chk("nomacro valid", 32'(tx_valid), 32'd1);
      @(negedge clk);
      chk("nomacro done", 32'(busy), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
